// File: rtl/cbd_poly_buffer_if.sv
// Bundles the sampler-facing write side, the NTT-facing read port and the status flags of cbd_poly_buffer.
interface cbd_poly_buffer_if;
    logic        in_valid;
    logic [47:0] in_data;
    logic        in_ready;
    logic        clear;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [11:0] rd_data;
    logic        poly_valid;
    logic [6:0]  wr_count;
    logic        overflow;
    logic        bad_coef;

    modport master (
        output in_valid, in_data, clear, rd_en, rd_addr,
        input  in_ready, rd_data, poly_valid, wr_count, overflow, bad_coef
    );

    modport slave (
        input  in_valid, in_data, clear, rd_en, rd_addr,
        output in_ready, rd_data, poly_valid, wr_count, overflow, bad_coef
    );
endinterface

// File: rtl/cbd_poly_buffer.sv
// Stores one CBD-sampled polynomial (four 12-bit lanes per word), reduced into [0, Q),
// and serves it through a registered random-access read port.
module cbd_poly_buffer #(
    parameter int Q      = 3329,
    parameter int COEF_W = 12,
    parameter int N      = 256
) (
    input  logic              clk,
    input  logic              reset,
    cbd_poly_buffer_if.slave  bus
);
    localparam int WORDS = N / 4;
    localparam logic [COEF_W-1:0] NEG_OFFSET = COEF_W'((1 << COEF_W) - Q);

    typedef enum logic {FILL, FULL} state_t;

    state_t              state_q, state_d;
    logic [6:0]          wrCount_q, wrCount_d;
    logic                overflow_q, overflow_d;
    logic                badCoef_q, badCoef_d;
    logic [COEF_W-1:0]   rdData_q, rdData_d;
    logic                wrEn;
    logic [4*COEF_W-1:0] reducedWord;
    logic                anyIllegal;
    logic [4*COEF_W-1:0] rdWord;
    logic [4*COEF_W-1:0] mem_q [WORDS];

    // Negative lanes wrap to x - 2^12 + Q; legality is judged on the raw two's-complement value.
    always_comb begin
        reducedWord = '0;
        anyIllegal  = 1'b0;
        for (int j = 0; j < 4; j++) begin
            logic [COEF_W-1:0] lane;
            lane = bus.in_data[j*COEF_W +: COEF_W];
            reducedWord[j*COEF_W +: COEF_W] = lane[COEF_W-1] ? (lane - NEG_OFFSET) : lane;
            if (!(lane == 12'h000 || lane == 12'h001 || lane == 12'h002 ||
                  lane == 12'hFFE || lane == 12'hFFF)) begin
                anyIllegal = 1'b1;
            end
        end
    end

    // clear beats a same-cycle in_valid, so a discarded word never touches count or flags.
    always_comb begin
        state_d    = state_q;
        wrCount_d  = wrCount_q;
        overflow_d = overflow_q;
        badCoef_d  = badCoef_q;
        wrEn       = 1'b0;
        if (bus.clear) begin
            state_d    = FILL;
            wrCount_d  = '0;
            overflow_d = 1'b0;
            badCoef_d  = 1'b0;
        end else if (bus.in_valid) begin
            if (state_q == FILL) begin
                wrEn      = 1'b1;
                wrCount_d = wrCount_q + 7'd1;
                if (anyIllegal) begin
                    badCoef_d = 1'b1;
                end
                if (wrCount_q == 7'(WORDS - 1)) begin
                    state_d = FULL;
                end
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FILL;
            wrCount_q  <= '0;
            overflow_q <= 1'b0;
            badCoef_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wrCount_q  <= wrCount_d;
            overflow_q <= overflow_d;
            badCoef_q  <= badCoef_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem_q[wrCount_q[5:0]] <= reducedWord;
        end
    end

    always_comb begin
        rdWord   = mem_q[bus.rd_addr[7:2]];
        rdData_d = rdData_q;
        if (bus.rd_en) begin
            case (bus.rd_addr[1:0])
                2'd0:    rdData_d = rdWord[0*COEF_W +: COEF_W];
                2'd1:    rdData_d = rdWord[1*COEF_W +: COEF_W];
                2'd2:    rdData_d = rdWord[2*COEF_W +: COEF_W];
                default: rdData_d = rdWord[3*COEF_W +: COEF_W];
            endcase
        end
    end

    // Reading the array before the write lands gives read-before-write on a shared word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdData_q <= '0;
        end else begin
            rdData_q <= rdData_d;
        end
    end

    assign bus.rd_data    = rdData_q;
    assign bus.poly_valid = (state_q == FULL);
    assign bus.in_ready   = (state_q == FILL);
    assign bus.wr_count   = wrCount_q;
    assign bus.overflow   = overflow_q;
    assign bus.bad_coef   = badCoef_q;
endmodule

// File: tb/tb_cbd_poly_buffer.sv
// Randomized scoreboard bench for cbd_poly_buffer against a coefficient-level reference model.
module tb_cbd_poly_buffer;
    logic clk;
    logic reset;
    cbd_poly_buffer_if bus ();

    cbd_poly_buffer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compareCount = 0;
    int failCount    = 0;

    // Reference model: reduced coefficient per index, whether it is defined, and status.
    int  refCoef  [256];
    bit  refKnown [256];
    int  refCount;
    bit  refFull;
    bit  refOverflow;
    bit  refBad;
    bit  badKnown;
    int  expQ [$];
    logic rdSeen;

    function automatic int signedLane(input logic [11:0] x);
        return (x >= 12'd2048) ? int'(x) - 4096 : int'(x);
    endfunction

    function automatic int reduceLane(input logic [11:0] x);
        int v;
        v = signedLane(x);
        return (v < 0) ? v + 3329 : v;
    endfunction

    function automatic bit legalLane(input logic [11:0] x);
        int v;
        v = signedLane(x);
        return (v >= -2) && (v <= 2);
    endfunction

    function automatic logic [11:0] randLane();
        if ($urandom_range(15) == 0) return 12'($urandom_range(4095));
        case ($urandom_range(4))
            0:       return 12'h000;
            1:       return 12'h001;
            2:       return 12'h002;
            3:       return 12'hFFE;
            default: return 12'hFFF;
        endcase
    endfunction

    function automatic logic [47:0] randWord();
        return {randLane(), randLane(), randLane(), randLane()};
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compareCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkStatus();
        checkOutput("wr_count", int'(bus.wr_count), refCount);
        checkOutput("poly_valid", int'(bus.poly_valid), int'(refFull));
        checkOutput("in_ready", int'(bus.in_ready), int'(!refFull));
        checkOutput("overflow", int'(bus.overflow), int'(refOverflow));
        if (badKnown) checkOutput("bad_coef", int'(bus.bad_coef), int'(refBad));
    endtask

    task automatic idleInputs();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.clear    = 1'b0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
    endtask

    // One clock cycle: drive, predict the edge's effect, then check status after the edge.
    task automatic applyStimulus(input bit v, input logic [47:0] d, input bit c,
                                 input bit re, input logic [7:0] a);
        bit illegal;
        @(negedge clk);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.clear    = c;
        bus.rd_en    = re;
        bus.rd_addr  = a;
        if (re) expQ.push_back(refKnown[a] ? refCoef[a] : -1);
        illegal = 1'b0;
        for (int j = 0; j < 4; j++) if (!legalLane(d[j*12 +: 12])) illegal = 1'b1;
        if (c) begin
            refCount = 0; refFull = 0; refOverflow = 0; refBad = 0; badKnown = 1;
        end else if (v) begin
            if (!refFull) begin
                for (int j = 0; j < 4; j++) begin
                    refCoef[refCount*4 + j]  = reduceLane(d[j*12 +: 12]);
                    refKnown[refCount*4 + j] = 1'b1;
                end
                if (illegal) refBad = 1;
                refCount++;
                if (refCount == 64) refFull = 1;
            end else begin
                refOverflow = 1;
                if (illegal) badKnown = 0;
            end
        end
        @(posedge clk);
        #1;
        idleInputs();
        checkStatus();
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        refCount = 0; refFull = 0; refOverflow = 0; refBad = 0; badKnown = 1;
        #1;
        checkOutput("rd_data_reset", int'(bus.rd_data), 0);
        checkStatus();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic readWord(input int k);
        applyStimulus(0, '0, 0, 1, 8'(k));
    endtask

    // Monitor: any cycle whose edge sampled rd_en yields one rd_data to score.
    always @(posedge clk or posedge reset) begin
        if (reset) rdSeen <= 1'b0;
        else       rdSeen <= bus.rd_en;
    end

    always @(negedge clk) begin
        if (rdSeen) begin
            if (expQ.size() == 0) begin
                compareCount++;
                failCount++;
                $display("[TB] FAIL rd_underflow: got a read with no expectation queued");
            end else begin
                int e;
                e = expQ.pop_front();
                if (e >= 0) checkOutput("rd_data", int'(bus.rd_data), e);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin refCoef[i] = 0; refKnown[i] = 0; end
        rdSeen = 1'b0;
        idleInputs();
        reset = 1'b0;
        doReset();

        // Fixed pattern fill, then boundary reads.
        for (int i = 0; i < 64; i++) applyStimulus(1, 48'h002_001_000_FFF, 0, 0, 0);
        checkOutput("poly_valid_plan", int'(bus.poly_valid), 1);
        foreach (expQ[i]) ;
        readWord(0); readWord(1); readWord(2); readWord(3); readWord(255);
        readWord(0);
        checkOutput("k0_model", refCoef[0], 3328);

        // Overflow while FULL.
        for (int i = 0; i < 3; i++) applyStimulus(1, 48'h111111111111, 0, 0, 0);
        readWord(0);

        // 0xFFE lane and an illegal lane.
        applyStimulus(0, '0, 1, 0, 0);
        applyStimulus(1, 48'h000_000_000_FFE, 0, 0, 0);
        readWord(0);
        applyStimulus(1, 48'h000_000_005_000, 0, 0, 0);
        readWord(5);
        applyStimulus(0, '0, 1, 0, 0);

        // Gapped fill, mid-fill reset, then refill with interleaved reads.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, randWord(), 0, 0, 0);
            applyStimulus(0, '0, 0, 1, 8'($urandom_range(255)));
            applyStimulus(0, '0, 0, 0, 0);
        end
        doReset();
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1, randWord(), 0, $urandom_range(1), 8'($urandom_range(255)));
        end
        applyStimulus(1, randWord(), 0, 1, 8'(4 * (i_last())));

        // clear racing in_valid at wr_count=10, then read-after-write on word 2.
        applyStimulus(0, '0, 1, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(1, randWord(), 0, 0, 0);
        applyStimulus(1, 48'h001_002_FFE_FFF, 1, 0, 0);
        readWord(40); readWord(41);
        applyStimulus(1, randWord(), 0, 0, 0);
        applyStimulus(1, randWord(), 0, 0, 0);
        applyStimulus(1, 48'h000_000_000_002, 0, 1, 8);
        readWord(8);

        // Random traffic: same-word read/write collisions included.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] a;
            a = ($urandom_range(3) == 0) ? 8'((refCount % 64) * 4 + $urandom_range(3))
                                         : 8'($urandom_range(255));
            applyStimulus($urandom_range(2) != 0, randWord(), $urandom_range(150) == 0,
                          $urandom_range(1), a);
        end

        applyStimulus(0, '0, 0, 0, 0);
        applyStimulus(0, '0, 0, 0, 0);
        if (expQ.size() != 0) begin
            compareCount++;
            failCount++;
            $display("[TB] FAIL rd_pending: got %0d unanswered reads, expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

    function automatic int i_last();
        return 63;
    endfunction
endmodule

// File: doc/cbd_poly_buffer.md
# cbd_poly_buffer

Collects the packed 48-bit coefficient words produced by the eta=2 centered-binomial sampler. It reduces each signed 12-bit coefficient into the canonical range [0, Q) and stores one 256-coefficient polynomial. It then presents the polynomial to the downstream NTT/arithmetic stage through a registered random-access read port. It sits directly downstream of the sampler: its `Out`/`done` become this block's `in_data`/`in_valid`.

## Interface
- `Q`, 3329, modulus used for reducing negative coefficients
- `COEF_W`, 12, coefficient width in bits
- `N`, 256, coefficients per polynomial (N/4 = 64 input words)
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  one 48-bit word offered this cycle; there is no backpressure
- `in_data`  in  48  four two's-complement 12-bit coefficients; lane j = bits [12j+11:12j], lane 0 first
- `in_ready`  out  1  high while in FILL; informational only
- `clear`  in  1  single-cycle pulse: discard the polynomial and restart filling
- `rd_en`  in  1  read request
- `rd_addr`  in  8  coefficient index k (0..255)
- `rd_data`  out  12  reduced coefficient, registered
- `poly_valid`  out  1  all 256 coefficients stored
- `wr_count`  out  7  accepted words, 0..64
- `overflow`  out  1  sticky: `in_valid` arrived while FULL
- `bad_coef`  out  1  sticky: an input lane held a value outside {-2..2}

## Operation
- Storage: 64 x 48-bit array. Word index = k>>2; lane = k[1:0]. The array is not reset.
- Per-lane reduction (combinational, before the write), lane value x:
  - x[11]=0: store x.
  - x[11]=1: store x - 767 (mod 2^12), i.e. x - 4096 + Q.
  - 0xFFE -> 3327 and 0xFFF -> 3328.
  - Legal inputs are 0x000, 0x001, 0x002, 0xFFE, 0xFFF. Any other value sets `bad_coef`; the value is still stored using the same rule.
- State FILL (reset state):
  - On `in_valid`: write the reduced word at `wr_count[5:0]`, then increment `wr_count`.
  - The write that makes `wr_count`=64 moves the block to FULL.
- State FULL:
  - `poly_valid`=1 and `in_ready`=0.
  - Any `in_valid` is dropped and sets `overflow`; the array and `wr_count` are unchanged.
- `clear` (either state):
  - Next state FILL; `wr_count`=0, `poly_valid`=0, `overflow`=0, `bad_coef`=0.
  - `clear` takes priority over a simultaneous `in_valid`: that word is discarded, is not counted, and is not checked for `bad_coef`.
- Reads are legal in both states. In FILL they return whatever the array holds, which may be stale. `rd_data` holds its value when `rd_en`=0.
- Reset (async, mid-operation allowed): state FILL; `wr_count`=0, `poly_valid`=0, `in_ready`=1, `rd_data`=0, `overflow`=0, `bad_coef`=0. An in-progress fill is abandoned.

## Timing
- Write: `in_valid` sampled at edge t; data is in the array and `wr_count` is incremented after edge t. A read issued in cycle t+1 returns the new data.
- Back-to-back `in_valid` is accepted every cycle; a polynomial fills in a minimum of 64 cycles.
- `poly_valid` rises on the same edge as the 64th accepted write. It stays high until `clear` or `reset`.
- Read latency 1: `rd_en`/`rd_addr` sampled at edge t; `rd_data` is valid after edge t. Reads are fully pipelined at one per cycle.
- Same-cycle write and read of the same word: the read returns the old contents (read-before-write).
- `overflow` and `bad_coef` assert on the edge that samples the offending word.
- `wr_count` never exceeds 64 and never wraps.

## Test plan
- Reset, then 64 words 0x002_001_000_FFF (lanes 0..3 = 0xFFF, 0x000, 0x001, 0x002) on consecutive cycles -> `poly_valid`=1 after the 64th edge, `wr_count`=64; reading k=0..3 returns 3328, 0, 1, 2; k=255 returns 2.
- Lane 0 = 0xFFE, every other lane = 0 -> k=0 reads 3327; `bad_coef` stays 0.
- One word with lane 1 = 0x005 -> `bad_coef`=1 (sticky), k=1 reads 5; `clear` -> `bad_coef`=0, `wr_count`=0.
- Fill to FULL, then 3 more `in_valid` words of 0x111111111111 -> `overflow`=1, `wr_count`=64, contents unchanged (k=0 still 3328).
- Gapped input (`in_valid` every 3rd cycle, 20 words), then `reset` for one cycle -> `wr_count`=0, `poly_valid`=0, `rd_data`=0. Refill with 64 words -> `poly_valid`=1.
- `clear` and `in_valid` in the same cycle in FILL with `wr_count`=10 -> `wr_count`=0 and the word is not stored. `rd_en` with `rd_addr`=8 on the cycle after a write to word 2 -> returns the new reduced lane-0 value.
